// File: rtl/sdp_ram_be_if.sv
// Write/read port bundle for sdp_ram_be: producer-side write channel plus consumer-side read channel.
interface sdp_ram_be_if #(
  parameter int DLEN = 32,
  parameter int ALEN = 4,
  parameter int BLEN = 8
);
  localparam int NB = DLEN / BLEN;

  logic            i_wen;
  logic [NB-1:0]   i_wbe;
  logic [ALEN-1:0] i_waddr;
  logic [DLEN-1:0] i_wdata;
  logic            i_ren;
  logic [ALEN-1:0] i_raddr;
  logic            o_rvalid;
  logic [DLEN-1:0] o_rdata;

  modport master (
    output i_wen, i_wbe, i_waddr, i_wdata, i_ren, i_raddr,
    input  o_rvalid, o_rdata
  );

  modport slave (
    input  i_wen, i_wbe, i_waddr, i_wdata, i_ren, i_raddr,
    output o_rvalid, o_rdata
  );
endinterface

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a registered read-valid pulse.
module sdp_ram_be #(
  parameter int              DLEN     = 32,
  parameter int              ALEN     = 4,
  parameter int              BLEN     = 8,
  parameter int              RD_LAT   = 1,
  parameter int              RDW_MODE = 0,
  parameter logic [DLEN-1:0] RST_VAL  = '0
) (
  input  logic        clk,
  input  logic        rst,
  sdp_ram_be_if.slave bus
);
  localparam int NB    = DLEN / BLEN;
  localparam int DEPTH = 1 << ALEN;

  if (DLEN % BLEN != 0) begin : g_chk_dlen
    $fatal(1, "sdp_ram_be: DLEN must be a multiple of BLEN");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
    $fatal(1, "sdp_ram_be: RD_LAT must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_chk_rdw
    $fatal(1, "sdp_ram_be: RDW_MODE must be 0 or 1");
  end

  // Take new lanes where the byte enable is set, keep the old ones elsewhere.
  function automatic logic [DLEN-1:0] merge_lanes(input logic [DLEN-1:0] old_w,
                                                  input logic [DLEN-1:0] new_w,
                                                  input logic [NB-1:0]   be);
    logic [DLEN-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[k*BLEN +: BLEN] = new_w[k*BLEN +: BLEN];
    end
    return res;
  endfunction

  logic [DLEN-1:0] mem [DEPTH];
  logic [DLEN-1:0] old_word;
  logic [DLEN-1:0] rd_word;
  logic            rdw_hit;
  logic            rvalid_q;
  logic [DLEN-1:0] rdata_q;

  // Array is deliberately not reset; writes proceed even while rst is high.
  always_ff @(posedge clk) begin
    if (bus.i_wen) mem[bus.i_waddr] <= merge_lanes(mem[bus.i_waddr], bus.i_wdata, bus.i_wbe);
  end

  assign old_word = mem[bus.i_raddr];
  assign rdw_hit  = bus.i_wen && (bus.i_raddr == bus.i_waddr);
  assign rd_word  = (RDW_MODE == 1 && rdw_hit) ? merge_lanes(old_word, bus.i_wdata, bus.i_wbe)
                                               : old_word;

  if (RD_LAT == 1) begin : g_lat1
    logic            vld_p0;
    logic [DLEN-1:0] rdata_p0;

    // Stage p0: array read registered straight to the output.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p0   <= 1'b0;
        rdata_p0 <= RST_VAL;
      end else begin
        vld_p0 <= bus.i_ren;
        if (bus.i_ren) rdata_p0 <= rd_word;
      end
    end

    assign rvalid_q = vld_p0;
    assign rdata_q  = rdata_p0;
  end else begin : g_lat2
    logic            vld_p0;
    logic [DLEN-1:0] data_p0;
    logic            vld_p1;
    logic [DLEN-1:0] rdata_p1;

    // Stage p0: array read captured on the request edge, so the RDW result matches RD_LAT=1.
    always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= bus.i_ren;
    end

    always_ff @(posedge clk) begin
      if (bus.i_ren) data_p0 <= rd_word;
    end

    // Stage p1: output register; reset drops whatever was in flight in p0.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1   <= 1'b0;
        rdata_p1 <= RST_VAL;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) rdata_p1 <= data_p0;
      end
    end

    assign rvalid_q = vld_p1;
    assign rdata_q  = rdata_p1;
  end

  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
endmodule
